demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Inverse of the clocked mux datapath: takes one input stream and steers each word to one of NUM_OUT output channels, chosen by select `s`.
- Each output channel has a 1-deep registered holding slot with valid/ready flow control.
- Sits downstream of stream producers. Used by the mux bench environment to fan traffic back out per channel.

Parameters:
- DATA_W, 8, width of each data word.
- NUM_OUT, 4, number of output channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_OUT.
- CNT_W, 16, width of the forwarded-word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted this cycle when in_valid && in_ready.
- in  input  DATA_W  input data word.
- s  input  SEL_W  destination channel; sampled with `in`.
- op_valid  output  NUM_OUT  per-channel output valid.
- op_ready  input  NUM_OUT  per-channel output ready.
- op  output  NUM_OUT*DATA_W  flattened output data; channel k occupies bits [k*DATA_W +: DATA_W].
- err_sel  output  1  sticky flag: a word was accepted with s >= NUM_OUT.
- err_clr  input  1  synchronous clear of err_sel.
- fwd_count  output  CNT_W  count of words delivered into a channel slot.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous-release usage): all outputs go to 0.
  - op_valid, op, err_sel and fwd_count are 0.
  - Buffered words are discarded. Reset mid-transfer loses slot contents with no partial output.
- Per channel k: slot register data_k plus full flag.
  - op_valid[k] = full_k.
  - op[k] = data_k, held stable while op_valid[k] && !op_ready[k].
- Output drain: when op_valid[k] && op_ready[k] at a clock edge, full_k clears, unless refilled in the same cycle.
- in_ready is combinational from s, full and op_ready:
  - s < NUM_OUT: in_ready = !full[s] || op_ready[s] (pass-through on simultaneous drain).
  - s >= NUM_OUT: in_ready = 1. The word is accepted and dropped.
- Accept (in_valid && in_ready, s valid):
  - data_s <= in and full_s <= 1 at that edge. Latency 1 cycle, in to op_valid.
  - fwd_count increments by 1 and wraps from 2**CNT_W-1 to 0.
- Simultaneous drain and fill on the same channel: the new word is loaded, op_valid stays 1 with no bubble, and the old word counts as consumed.
- Drains on other channels proceed in parallel. At most one fill per cycle. Unselected channels hold their state.
- Invalid select accept: no slot changes, fwd_count unchanged, err_sel <= 1.
- err_sel:
  - err_clr = 1 clears it next edge.
  - If err_clr and a new invalid accept occur in the same cycle, err_sel = 1 (set wins).
- in_valid low: no state change except drains. `in` and `s` are don't-care.
- Producer rule (checked by assertion): in, s and in_valid must be held while in_valid && !in_ready.
- Throughput: 1 word/cycle to any channel whose consumer holds op_ready high.

Test Plan:
- Reset then idle: rst low 20 ns, release.
  - op_valid=4'b0000, op=0, fwd_count=0, err_sel=0, in_ready=1 for every s.
- Single route: in=8'hA5, s=2, in_valid 1 cycle, op_ready=0.
  - Next cycle op_valid=4'b0100, op[23:16]=8'hA5, fwd_count=1.
  - Word held 5 cycles. op_ready[2]=1 for one cycle, then op_valid=4'b0000.
- Backpressure: channel 1 full, op_ready[1]=0, in=8'h3C, s=1, in_valid=1.
  - in_ready=0, slot keeps old word.
  - Raise op_ready[1]: same cycle in_ready=1, next cycle op[15:8]=8'h3C, op_valid[1] stays 1.
- Streaming: op_ready=4'b1111, words 0x00..0x0F with s = i%4 on consecutive cycles.
  - Each appears on channel i%4 exactly 1 cycle later, no stalls, fwd_count=16.
- Invalid select (NUM_OUT=3, SEL_W=2): in=8'h77, s=3.
  - in_ready=1, no op_valid change, fwd_count unchanged, err_sel=1.
  - err_clr pulse leads to err_sel=0. err_clr plus a simultaneous invalid accept leaves err_sel=1.
- Reset mid-operation and wrap: fill all 4 slots, assert rst asynchronously between edges.
  - op_valid goes 0 immediately.
  - Separately, preload fwd_count to 16'hFFFF via 65535 transfers; one more accept gives 16'h0000.

Source files
------------

// File: rtl/demux_router.sv
// demux_router: steers one input stream to NUM_OUT output channels, picked by `s`.
// Each channel has a 1-deep registered slot with valid/ready handshaking.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   input word accepted when in_valid && in_ready (combinational)
//   in         input data word
//   s          destination channel, sampled with `in`
//   op_valid   per-channel slot full
//   op_ready   per-channel consumer ready
//   op         flattened channel data, channel k at [k*DATA_W +: DATA_W]
//   err_sel    sticky: a word was accepted with s >= NUM_OUT
//   err_clr    synchronous clear of err_sel (a same-cycle set wins)
//   fwd_count  wrapping count of words loaded into a channel slot
module demux_router #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in,
  input  logic [SEL_W-1:0]          s,
  output logic [NUM_OUT-1:0]        op_valid,
  input  logic [NUM_OUT-1:0]        op_ready,
  output logic [NUM_OUT*DATA_W-1:0] op,
  output logic                      err_sel,
  input  logic                      err_clr,
  output logic [CNT_W-1:0]          fwd_count
);

  localparam int unsigned NumSel = 2 ** SEL_W;
  localparam logic [SEL_W:0] NumOutSel = (SEL_W + 1)'(NUM_OUT);

  logic [NUM_OUT-1:0]        full_q, full_d;
  logic [NUM_OUT*DATA_W-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Zero-padded to the full select range so any value of `s` indexes in bounds.
  logic [NumSel-1:0] full_ext, ready_ext;
  logic              sel_ok, accept, fill;

  assign full_ext  = NumSel'(full_q);
  assign ready_ext = NumSel'(op_ready);
  assign sel_ok    = {1'b0, s} < NumOutSel;

  // Out-of-range selects are always accepted and dropped so the producer never stalls.
  assign in_ready = sel_ok ? (!full_ext[s] || ready_ext[s]) : 1'b1;
  assign accept   = in_valid && in_ready;
  assign fill     = accept && sel_ok;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (full_q[k] && op_ready[k]) begin
        full_d[k] = 1'b0;
      end
      // Fill after drain so a same-cycle refill keeps the slot full with no bubble.
      if (fill && (s == SEL_W'(k))) begin
        full_d[k]                    = 1'b1;
        data_d[k*DATA_W +: DATA_W]   = in;
      end
    end
    if (fill) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (accept && !sel_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign op_valid  = full_q;
  assign op        = data_q;
  assign err_sel   = err_q;
  assign fwd_count = cnt_q;

  // A stalled producer must hold its word and destination until accepted.
  property p_producer_hold;
    @(posedge clk) disable iff (!rst)
      (in_valid && !in_ready) |=> (in_valid && $stable(in) && $stable(s));
  endproperty
  a_producer_hold: assert property (p_producer_hold);

endmodule

// File: tb/tb_demux_router.sv
module tb_demux_router;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  din;
  logic [1:0]  sel;
  logic [3:0]  op_valid, op_ready;
  logic [31:0] op;
  logic        err_sel, err_clr;
  logic [15:0] fwd_count;

  // Three-channel instance for the invalid-select cases.
  logic        in_valid3, in_ready3;
  logic [7:0]  din3;
  logic [1:0]  sel3;
  logic [2:0]  op_valid3, op_ready3;
  logic [23:0] op3;
  logic        err_sel3, err_clr3;
  logic [15:0] fwd_count3;

  int checks = 0;
  int errors = 0;

  demux_router u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din), .s(sel),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .err_sel(err_sel), .err_clr(err_clr),
    .fwd_count(fwd_count)
  );

  demux_router #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in(din3), .s(sel3),
    .op_valid(op_valid3), .op_ready(op_ready3), .op(op3), .err_sel(err_sel3),
    .err_clr(err_clr3), .fwd_count(fwd_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic [1:0]  s;
    logic [3:0]  rdy;
    logic        exp_ir;
    logic [3:0]  exp_valid;
    logic [31:0] exp_op;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Route, hold, drain, backpressure, pass-through, parallel drain.
    vecs[0]  = '{1'b1, 8'hA5, 2'd2, 4'b0000, 1'b1, 4'b0100, 32'h00A5_0000, 16'd1};
    vecs[1]  = '{1'b0, 8'h00, 2'd2, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000, 16'd1};
    vecs[2]  = '{1'b0, 8'h00, 2'd2, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000, 16'd1};
    vecs[3]  = '{1'b0, 8'h00, 2'd2, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000, 16'd1};
    vecs[4]  = '{1'b0, 8'h00, 2'd2, 4'b0000, 1'b0, 4'b0100, 32'h00A5_0000, 16'd1};
    vecs[5]  = '{1'b0, 8'h00, 2'd2, 4'b0100, 1'b1, 4'b0000, 32'h00A5_0000, 16'd1};
    vecs[6]  = '{1'b1, 8'h11, 2'd1, 4'b0000, 1'b1, 4'b0010, 32'h00A5_1100, 16'd2};
    vecs[7]  = '{1'b1, 8'h3C, 2'd1, 4'b0000, 1'b0, 4'b0010, 32'h00A5_1100, 16'd2};
    vecs[8]  = '{1'b1, 8'h3C, 2'd1, 4'b0010, 1'b1, 4'b0010, 32'h00A5_3C00, 16'd3};
    vecs[9]  = '{1'b1, 8'h5A, 2'd3, 4'b0010, 1'b1, 4'b1000, 32'h5AA5_3C00, 16'd4};
    vecs[10] = '{1'b1, 8'hC3, 2'd0, 4'b0000, 1'b1, 4'b1001, 32'h5AA5_3CC3, 16'd5};
    vecs[11] = '{1'b0, 8'h00, 2'd0, 4'b1001, 1'b1, 4'b0000, 32'h5AA5_3CC3, 16'd5};
    vecs[12] = '{1'b1, 8'hE7, 2'd2, 4'b0100, 1'b1, 4'b0100, 32'h5AE7_3CC3, 16'd6};

    rst = 1'b0;
    in_valid = 1'b0; din = '0; sel = '0; op_ready = '0; err_clr = 1'b0;
    in_valid3 = 1'b0; din3 = '0; sel3 = '0; op_ready3 = '0; err_clr3 = 1'b0;

    // Reset then idle.
    #20 rst = 1'b1;
    #2;
    check("rst_valid", 64'(op_valid), 64'h0);
    check("rst_op", 64'(op), 64'h0);
    check("rst_cnt", 64'(fwd_count), 64'h0);
    check("rst_err", 64'(err_sel), 64'h0);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1 check($sformatf("rst_ready_s%0d", i), 64'(in_ready), 64'h1);
    end
    sel = '0;
    step();

    // Invalid select on the 3-channel instance.
    in_valid3 = 1'b1; din3 = 8'h12; sel3 = 2'd0;
    #1 check("inv_ready_ok", 64'(in_ready3), 64'h1);
    step();
    check("inv_valid_fill", 64'(op_valid3), 64'h1);
    check("inv_data_fill", 64'(op3), 64'h12);
    check("inv_cnt_fill", 64'(fwd_count3), 64'h1);
    din3 = 8'h77; sel3 = 2'd3;
    #1 check("inv_ready_bad", 64'(in_ready3), 64'h1);
    step();
    check("inv_valid_hold", 64'(op_valid3), 64'h1);
    check("inv_data_hold", 64'(op3), 64'h12);
    check("inv_cnt_hold", 64'(fwd_count3), 64'h1);
    check("inv_err_set", 64'(err_sel3), 64'h1);
    in_valid3 = 1'b0; err_clr3 = 1'b1;
    step();
    check("inv_err_clr", 64'(err_sel3), 64'h0);
    in_valid3 = 1'b1;
    step();
    check("inv_err_set_wins", 64'(err_sel3), 64'h1);
    in_valid3 = 1'b0;
    step();
    check("inv_err_clr2", 64'(err_sel3), 64'h0);
    err_clr3 = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; din = vecs[i].d; sel = vecs[i].s; op_ready = vecs[i].rdy;
      #1 check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
      step();
      check($sformatf("vec%0d_valid", i), 64'(op_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_op", i), 64'(op), 64'(vecs[i].exp_op));
      check($sformatf("vec%0d_cnt", i), 64'(fwd_count), 64'(vecs[i].exp_cnt));
    end

    // Fill remaining slots, then reset asynchronously between edges.
    op_ready = 4'b0000;
    in_valid = 1'b1; din = 8'h01; sel = 2'd0; step();
    din = 8'h02; sel = 2'd1; step();
    din = 8'h03; sel = 2'd3; step();
    in_valid = 1'b0;
    check("full_valid", 64'(op_valid), 64'hF);
    check("full_op", 64'(op), 64'h03E7_0201);
    check("full_cnt", 64'(fwd_count), 64'd9);
    #3 rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(op_valid), 64'h0);
    check("async_rst_op", 64'(op), 64'h0);
    check("async_rst_cnt", 64'(fwd_count), 64'h0);
    @(negedge clk) rst = 1'b1;
    step();

    // Streaming with all consumers ready.
    op_ready = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; din = 8'(i); sel = 2'(i % 4);
      #1 check($sformatf("stream%0d_ready", i), 64'(in_ready), 64'h1);
      step();
      check($sformatf("stream%0d_valid", i), 64'(op_valid), 64'(4'b0001 << (i % 4)));
      check($sformatf("stream%0d_data", i), 64'(op[(i % 4) * 8 +: 8]), 64'(i));
    end
    in_valid = 1'b0;
    check("stream_cnt", 64'(fwd_count), 64'd16);
    step();
    check("stream_drained", 64'(op_valid), 64'h0);

    // Counter wrap.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      din = 8'(i); sel = 2'(i % 4);
      step();
    end
    in_valid = 1'b0;
    check("wrap_max", 64'(fwd_count), 64'hFFFF);
    in_valid = 1'b1; din = 8'h99; sel = 2'd1;
    step();
    in_valid = 1'b0;
    check("wrap_zero", 64'(fwd_count), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
